// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
// Multi-cycle multiply/divide unit that owns the architectural HI/LO pair.
// Sits in EX: consumes HI/LO-class ops, supplies HI/LO to mfhi/mflo and
// stalls the pipeline while a multiply or divide is in flight.
//
// Handshake: a request is taken on a rising edge where start=1, the FSM is
// IDLE and flush=0. While busy, start is not taken; stall holds the
// requester in EX until busy falls, so it must keep start/op/a/b steady.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      HI/LO-class op valid in EX
//   op         0 MULT 1 MULTU 2 DIV 3 DIVU 4 MADD 5 MADDU 6 MSUB 7 MSUBU
//              8 MTHI 9 MTLO, 10-15 reserved (ignored)
//   a, b       rs / rt operands
//   read_hilo  mfhi/mflo in EX
//   flush      cancel in-flight op and any same-cycle start
//   hi, lo     HI / LO registers
//   busy       operation in flight
//   stall      hold EX and upstream
//   dbg_state  current FSM state (0 IDLE, 1 MUL, 2 DIV, 3 FIX)
module hilo_muldiv_unit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         read_hilo,
  input  logic         flush,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         busy,
  output logic         stall,
  output logic [1:0]   dbg_state
);

  localparam int CW = $clog2(W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MADD  = 4'd4;
  localparam logic [3:0] OP_MADDU = 4'd5;
  localparam logic [3:0] OP_MSUB  = 4'd6;
  localparam logic [3:0] OP_MSUBU = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic [W-1:0]  a_q, a_d;      // multiplicand, or dividend for div-by-zero
  logic [W-1:0]  b_q, b_d;      // multiplier, or |divisor|
  logic [W-1:0]  quo_q, quo_d;  // dividend shifting out / quotient shifting in
  logic [W-1:0]  rem_q, rem_d;  // partial remainder
  logic          sgn_q_q, sgn_q_d;
  logic          sgn_r_q, sgn_r_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;

  // Multiply datapath: sign/zero extend to 2W, then the 2W-bit product
  // modulo 2^2W is the correct two's complement result for both flavours.
  logic          mul_signed;
  logic [2*W-1:0] ext_a, ext_b, product, acc;
  logic          op_q_is_div;

  assign op_q_is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign mul_signed  = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
  assign ext_a       = mul_signed ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q};
  assign ext_b       = mul_signed ? {{W{b_q[W-1]}}, b_q} : {{W{1'b0}}, b_q};
  assign product     = ext_a * ext_b;
  assign acc         = {hi_q, lo_q};

  // One restoring-division step: shift the next dividend bit into the
  // remainder; subtract the divisor if it fits (no borrow out of bit W).
  logic [W:0] rem_shift, rem_diff;
  logic       q_bit;

  assign rem_shift = {rem_q, quo_q[W-1]};
  assign rem_diff  = rem_shift - {1'b0, b_q};
  assign q_bit     = ~rem_diff[W];

  // Operand magnitudes for signed divide.
  logic          div_signed_in;
  logic [W-1:0]  a_abs, b_abs;

  assign div_signed_in = (op == OP_DIV);
  assign a_abs = (div_signed_in && a[W-1]) ? (~a + 1'b1) : a;
  assign b_abs = (div_signed_in && b[W-1]) ? (~b + 1'b1) : b;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    sgn_q_d = sgn_q_q;
    sgn_r_d = sgn_r_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              op_d    = op;
              a_d     = a;
              b_d     = b;
              state_d = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              op_d = op;
              if (b == '0) begin
                // Divide by zero skips iteration; MUL state writes the
                // fixed result using the captured dividend.
                a_d     = a;
                state_d = S_MUL;
              end else begin
                quo_d   = a_abs;
                b_d     = b_abs;
                rem_d   = '0;
                sgn_q_d = div_signed_in & (a[W-1] ^ b[W-1]);
                sgn_r_d = div_signed_in & a[W-1];
                cnt_d   = '0;
                state_d = S_DIV;
              end
            end
            default: ;
          endcase
        end
      end

      S_MUL: begin
        state_d = S_IDLE;
        if (!flush) begin
          if (op_q_is_div) begin
            lo_d = '1;
            hi_d = a_q;
          end else if ((op_q == OP_MADD) || (op_q == OP_MADDU)) begin
            {hi_d, lo_d} = acc + product;
          end else if ((op_q == OP_MSUB) || (op_q == OP_MSUBU)) begin
            {hi_d, lo_d} = acc - product;
          end else begin
            {hi_d, lo_d} = product;
          end
        end
      end

      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          quo_d = {quo_q[W-2:0], q_bit};
          rem_d = q_bit ? rem_diff[W-1:0] : rem_shift[W-1:0];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(W - 1)) begin
            state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          lo_d = sgn_q_q ? (~quo_q + 1'b1) : quo_q;
          hi_d = sgn_r_q ? (~rem_q + 1'b1) : rem_q;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      sgn_q_q <= 1'b0;
      sgn_r_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      sgn_q_q <= sgn_q_d;
      sgn_r_q <= sgn_r_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = (state_q != S_IDLE);
  assign stall     = busy & (start | read_hilo);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        read_hilo;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic [1:0]  dbg_state;

  int vectors;
  int miscompares;

  hilo_muldiv_unit #(.W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .read_hilo (read_hilo),
    .flush     (flush),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .stall     (stall),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Advance one edge; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb);
    start = 1'b1;
    op    = o;
    a     = va;
    b     = vb;
    step();
    start = 1'b0;
  endtask

  // Wait for busy to fall; returns number of busy cycles observed.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0; op = 4'd0; a = '0; b = '0; read_hilo = 1'b0; flush = 1'b0;
    step(); step();
    vectors++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_hilo: hi=%h lo=%h expected 0/0", hi, lo);
    end
    vectors++;
    if (busy !== 1'b0 || stall !== 1'b0 || dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_ctl: busy=%b stall=%b state=%0d expected 0/0/0", busy, stall, dbg_state);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_mthi_mtlo();
    logic seen_busy;
    seen_busy = 1'b0;
    issue(4'd8, 32'h12345678, 32'h0);
    seen_busy |= busy;
    issue(4'd9, 32'h9ABCDEF0, 32'h0);
    seen_busy |= busy;
    vectors++;
    if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin
      miscompares++;
      $display("FAIL mthi_mtlo: hi=%h lo=%h expected 12345678/9abcdef0", hi, lo);
    end
    vectors++;
    if (seen_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mthi_mtlo_busy: busy=%b expected 0", seen_busy);
    end
  endtask

  task automatic test_mult();
    int n;
    issue(4'd0, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    vectors++;
    if (n !== 1) begin
      miscompares++;
      $display("FAIL mult_busy: cycles=%0d expected 1", n);
    end
    vectors++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
      miscompares++;
      $display("FAIL mult: hi=%h lo=%h expected ffffffff/fffffffa", hi, lo);
    end
    issue(4'd1, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    vectors++;
    if (hi !== 32'h00000002 || lo !== 32'hFFFFFFFA) begin
      miscompares++;
      $display("FAIL multu: hi=%h lo=%h expected 00000002/fffffffa", hi, lo);
    end
  endtask

  task automatic test_div();
    int n;
    issue(4'd2, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    vectors++;
    if (n !== 33) begin
      miscompares++;
      $display("FAIL div_busy: cycles=%0d expected 33", n);
    end
    vectors++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
      miscompares++;
      $display("FAIL div_neg: hi=%h lo=%h expected ffffffff/fffffffd", hi, lo);
    end
    issue(4'd3, 32'd100, 32'd7);
    wait_idle(n);
    vectors++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      miscompares++;
      $display("FAIL divu: hi=%h lo=%h expected 00000002/0000000e", hi, lo);
    end
    issue(4'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    vectors++;
    if (lo !== 32'h80000000 || hi !== 32'h0) begin
      miscompares++;
      $display("FAIL div_ovf: hi=%h lo=%h expected 00000000/80000000", hi, lo);
    end
    // 7 / -2: quotient -3, remainder +1 (sign of dividend)
    issue(4'd2, 32'd7, 32'hFFFFFFFE);
    wait_idle(n);
    vectors++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'h00000001) begin
      miscompares++;
      $display("FAIL div_negb: hi=%h lo=%h expected 00000001/fffffffd", hi, lo);
    end
  endtask

  task automatic test_madd_msub();
    int n;
    issue(4'd8, 32'h0, 32'h0);
    issue(4'd9, 32'd10, 32'h0);
    // 0xFFFFFFFF*2 = 0x1_FFFFFFFE; + 10 = 0x2_00000008
    issue(4'd5, 32'hFFFFFFFF, 32'd2);
    wait_idle(n);
    vectors++;
    if (hi !== 32'h00000002 || lo !== 32'h00000008) begin
      miscompares++;
      $display("FAIL maddu: hi=%h lo=%h expected 00000002/00000008", hi, lo);
    end
    // 0x2_00000008 - 9 = 0x1_FFFFFFFF
    issue(4'd6, 32'd1, 32'd9);
    wait_idle(n);
    vectors++;
    if (hi !== 32'h00000001 || lo !== 32'hFFFFFFFF) begin
      miscompares++;
      $display("FAIL msub: hi=%h lo=%h expected 00000001/ffffffff", hi, lo);
    end
    // signed MADD of -1*1 = -1: 0x1_FFFFFFFF - 1 = 0x1_FFFFFFFE
    issue(4'd4, 32'hFFFFFFFF, 32'd1);
    wait_idle(n);
    vectors++;
    if (hi !== 32'h00000001 || lo !== 32'hFFFFFFFE) begin
      miscompares++;
      $display("FAIL madd_neg: hi=%h lo=%h expected 00000001/fffffffe", hi, lo);
    end
    // MSUBU of 0xFFFFFFFF*0xFFFFFFFF = 0xFFFFFFFE_00000001 from 0x1_FFFFFFFE
    // -> 0x00000003_FFFFFFFD (mod 2^64)
    issue(4'd7, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle(n);
    vectors++;
    if (hi !== 32'h00000003 || lo !== 32'hFFFFFFFD) begin
      miscompares++;
      $display("FAIL msubu_wrap: hi=%h lo=%h expected 00000003/fffffffd", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int bad_stall;
    bad_stall = 0;
    issue(4'd3, 32'd100, 32'd7);
    // second request held in EX together with a HI/LO read
    start = 1'b1; op = 4'd8; a = 32'h0000CAFE; b = 32'h0;
    read_hilo = 1'b1;
    n = 0;
    while (busy && n < 100) begin
      if (stall !== 1'b1) bad_stall++;
      step();
      n++;
    end
    vectors++;
    if (n !== 33 || bad_stall !== 0) begin
      miscompares++;
      $display("FAIL b2b_stall: busy_cycles=%0d stall_low=%0d expected 33/0", n, bad_stall);
    end
    vectors++;
    if (stall !== 1'b0 || hi !== 32'd2 || lo !== 32'd14) begin
      miscompares++;
      $display("FAIL b2b_read: stall=%b hi=%h lo=%h expected 0/00000002/0000000e", stall, hi, lo);
    end
    step();
    start = 1'b0; read_hilo = 1'b0;
    vectors++;
    if (hi !== 32'h0000CAFE || lo !== 32'd14 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_second: hi=%h lo=%h busy=%b expected 0000cafe/0000000e/0", hi, lo, busy);
    end
  endtask

  task automatic test_flush();
    issue(4'd8, 32'h11111111, 32'h0);
    issue(4'd9, 32'h22222222, 32'h0);
    issue(4'd3, 32'd100, 32'd7);
    for (int i = 0; i < 9; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    vectors++;
    if (busy !== 1'b0 || dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL flush_state: busy=%b state=%0d expected 0/0", busy, dbg_state);
    end
    for (int i = 0; i < 40; i++) step();
    vectors++;
    if (hi !== 32'h11111111 || lo !== 32'h22222222) begin
      miscompares++;
      $display("FAIL flush_hilo: hi=%h lo=%h expected 11111111/22222222", hi, lo);
    end
    // flush with start in IDLE drops the start
    start = 1'b1; op = 4'd8; a = 32'hDEADBEEF; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    vectors++;
    if (hi !== 32'h11111111) begin
      miscompares++;
      $display("FAIL flush_start: hi=%h expected 11111111", hi);
    end
    // reserved op: no state change, no write
    issue(4'd12, 32'h33333333, 32'h44444444);
    vectors++;
    if (busy !== 1'b0 || hi !== 32'h11111111 || lo !== 32'h22222222) begin
      miscompares++;
      $display("FAIL reserved_op: busy=%b hi=%h lo=%h expected 0/11111111/22222222", busy, hi, lo);
    end
  endtask

  task automatic test_div_zero();
    int n;
    issue(4'd3, 32'd5, 32'd0);
    wait_idle(n);
    vectors++;
    if (n !== 1 || lo !== 32'hFFFFFFFF || hi !== 32'd5) begin
      miscompares++;
      $display("FAIL divu_zero: cycles=%0d hi=%h lo=%h expected 1/00000005/ffffffff", n, hi, lo);
    end
    issue(4'd2, 32'hFFFFFFFB, 32'd0);
    wait_idle(n);
    vectors++;
    if (n !== 1 || lo !== 32'hFFFFFFFF || hi !== 32'hFFFFFFFB) begin
      miscompares++;
      $display("FAIL div_zero: cycles=%0d hi=%h lo=%h expected 1/fffffffb/ffffffff", n, hi, lo);
    end
  endtask

  task automatic test_reset_mid_mult();
    issue(4'd0, 32'd3, 32'd5);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mult_inflight: busy=%b expected 1", busy);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: hi=%h lo=%h busy=%b expected 0/0/0", hi, lo, busy);
    end
    step();
    reset = 1'b0;
    step();
    vectors++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_after: hi=%h lo=%h busy=%b expected 0/0/0", hi, lo, busy);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_div();
    test_madd_msub();
    test_back_to_back();
    test_flush();
    test_div_zero();
    test_reset_mid_mult();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
